// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: shifter op codes and FSM states.
package shift_sequencer_pkg;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Existing 1-bit shifter: pass, logical left/right or arithmetic right by one position.
module shifter
    import shift_sequencer_pkg::*;
(
    input  logic [15:0] in,
    input  logic [1:0]  shift,
    output logic [15:0] sout
);

    always_comb begin
        sout = in;
        case (shift)
            SH_LSL:  sout = {in[14:0], 1'b0};
            SH_LSR:  sout = {1'b0, in[15:1]};
            SH_ASR:  sout = {in[15], in[15:1]};
            default: sout = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts {operand, op, amount}, iterates the 1-bit
// shifter once per clock, and returns the result plus the last bit shifted out.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [1:0]       in_shift,
    input  logic [AMT_W-1:0] in_amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_carry,
    output logic             busy
);

    state_t             state, state_next;
    logic [15:0]        acc, acc_next;
    logic [1:0]         op, op_next;
    logic [AMT_W-1:0]   cnt, cnt_next;
    logic               carry, carry_next;
    logic [15:0]        sout;

    shifter u_shifter (
        .in    (acc),
        .shift (op),
        .sout  (sout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            op        <= SH_PASS;
            cnt       <= '0;
            carry     <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            op    <= op_next;
            cnt   <= cnt_next;
            carry <= carry_next;
            // Result registers load only on entry to DONE so they hold through IDLE and SHIFT
            if (state_next == DONE && state != DONE) begin
                out_data  <= acc_next;
                out_carry <= carry_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        op_next    = op;
        cnt_next   = cnt;
        carry_next = carry;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_next   = in_data;
                    op_next    = in_shift;
                    cnt_next   = in_amount;
                    carry_next = 1'b0;
                    if (in_amount == '0 || in_shift == SH_PASS)
                        state_next = DONE;
                    else
                        state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                acc_next   = sout;
                cnt_next   = cnt - 1'b1;
                carry_next = (op == SH_LSL) ? acc[15] : acc[0];
                if (cnt == AMT_W'(1))
                    state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with hand-computed results and latencies.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_shift;
    logic [3:0]  in_amount;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    shift_sequencer #(.AMT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_amount (in_amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request, and counts edges after the accepting edge until out_valid (bounded).
    task automatic run_req(input logic [15:0] d, input logic [1:0] sh, input logic [3:0] amt,
                           output int n);
        @(negedge clk);
        in_data   = d;
        in_shift  = sh;
        in_amount = amt;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL reset_out_carry got=%b exp=0", out_carry); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lsl();
        int n;
        run_req(16'h8001, 2'b01, 4'd1, n);
        checks++; if (n !== 1) begin failures++; $display("FAIL lsl1_latency got=%0d exp=1", n); end
        checks++; if (out_data !== 16'h0002) begin failures++; $display("FAIL lsl1_data got=%h exp=0002", out_data); end
        checks++; if (out_carry !== 1'b1) begin failures++; $display("FAIL lsl1_carry got=%b exp=1", out_carry); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lsl1_busy got=%b exp=1", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lsl1_in_ready got=%b exp=0", in_ready); end
        drain();
    endtask

    task automatic test_asr();
        int n;
        run_req(16'h8000, 2'b11, 4'd4, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL asr4_latency got=%0d exp=4", n); end
        checks++; if (out_data !== 16'hF800) begin failures++; $display("FAIL asr4_data got=%h exp=f800", out_data); end
        checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL asr4_carry got=%b exp=0", out_carry); end
        drain();
    endtask

    task automatic test_lsr_and_max();
        int n;
        run_req(16'h00F0, 2'b10, 4'd5, n);
        checks++; if (n !== 5) begin failures++; $display("FAIL lsr5_latency got=%0d exp=5", n); end
        checks++; if (out_data !== 16'h0007) begin failures++; $display("FAIL lsr5_data got=%h exp=0007", out_data); end
        checks++; if (out_carry !== 1'b1) begin failures++; $display("FAIL lsr5_carry got=%b exp=1", out_carry); end
        drain();
        run_req(16'h0001, 2'b01, 4'd15, n);
        checks++; if (n !== 15) begin failures++; $display("FAIL lsl15_latency got=%0d exp=15", n); end
        checks++; if (out_data !== 16'h8000) begin failures++; $display("FAIL lsl15_data got=%h exp=8000", out_data); end
        checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL lsl15_carry got=%b exp=0", out_carry); end
        drain();
    endtask

    task automatic test_zero_pass();
        int n;
        run_req(16'h1234, 2'b01, 4'd0, n);
        checks++; if (n !== 0) begin failures++; $display("FAIL zero_latency got=%0d exp=0", n); end
        checks++; if (out_data !== 16'h1234) begin failures++; $display("FAIL zero_data got=%h exp=1234", out_data); end
        checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL zero_carry got=%b exp=0", out_carry); end
        drain();
        run_req(16'hBEEF, 2'b00, 4'd7, n);
        checks++; if (n !== 0) begin failures++; $display("FAIL pass_latency got=%0d exp=0", n); end
        checks++; if (out_data !== 16'hBEEF) begin failures++; $display("FAIL pass_data got=%h exp=beef", out_data); end
        checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL pass_carry got=%b exp=0", out_carry); end
        drain();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'hBEEF) begin failures++; $display("FAIL idle_hold_data got=%h exp=beef", out_data); end
    endtask

    task automatic test_back_to_back();
        int n;
        run_req(16'h0003, 2'b01, 4'd2, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", n); end
        // Second request pending while the first result is held under backpressure
        in_data   = 16'h00F0;
        in_shift  = 2'b10;
        in_amount = 4'd4;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== 16'h000C) begin failures++; $display("FAIL bp_out_data[%0d] got=%h exp=000c", i, out_data); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", n); end
        checks++; if (out_data !== 16'h000F) begin failures++; $display("FAIL b2b_data got=%h exp=000f", out_data); end
        checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL b2b_carry got=%b exp=0", out_carry); end
        drain();
    endtask

    task automatic test_reset_midshift();
        int n;
        @(negedge clk);
        in_data   = 16'h00FF;
        in_shift  = 2'b01;
        in_amount = 4'd10;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL mid_rst_out_data got=%h exp=0000", out_data); end
        @(negedge clk);
        reset = 1'b0;
        run_req(16'h00FF, 2'b01, 4'd4, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL post_rst_latency got=%0d exp=4", n); end
        checks++; if (out_data !== 16'h0FF0) begin failures++; $display("FAIL post_rst_data got=%h exp=0ff0", out_data); end
        checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL post_rst_carry got=%b exp=0", out_carry); end
        drain();
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = 2'b00;
        in_amount = '0;
        out_ready = 1'b0;
        test_reset();
        test_lsl();
        test_asr();
        test_lsr_and_max();
        test_zero_pass();
        test_back_to_back();
        test_reset_midshift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
